// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit -- instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Owns the program counter and fetches from instruction memory over a
// req/ack handshake. A two-entry holding queue (output slot + skid) feeds
// the IF/ID register. Redirects squash buffered and in-flight fetches.
//
// Parameters:
//   RESET_PC      address of the first fetch after reset
// Ports:
//   clk, rst_b    pipeline clock, asynchronous active-low reset
//   freeze        downstream stall (also freezes IF/ID)
//   redirect      taken branch/jump this cycle, target on redirect_pc
//   imem_req      fetch request, held until imem_ack
//   imem_addr     fetch address, stable while imem_req=1
//   imem_ack      one-cycle pulse, imem_rdata valid (may share req's cycle)
//   imem_rdata    fetched instruction word
//   pc_out        fetch address + 4 of the presented instruction
//   inst_out      presented instruction
//   inst_valid    output slot holds a valid instruction
//   flush_out     redirect | ~inst_valid (IF/ID flush)
// Optional (macro FETCH_PERF_EN):
//   perf_fetched  count of consumed instructions
//   perf_squashed count of discarded acks plus buffered entries dropped by
//                 a redirect
// ---------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        freeze,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] inst_out,
   output logic        inst_valid,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_squashed,
`endif
   output logic        flush_out
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} state_t;

   state_t      state;
   logic [31:0] pc, fetch_addr;
   logic [31:0] slot_inst, slot_pc4, skid_inst, skid_pc4;
   logic        slot_valid, skid_valid;

   logic        consume, ack_live, fetch_ok, to_skid;
   logic [31:0] fetch_pc4;

   assign imem_addr  = fetch_addr;
   assign inst_out   = slot_inst;
   assign pc_out     = slot_pc4;
   assign inst_valid = slot_valid;
   assign flush_out  = redirect | ~slot_valid;

   assign consume   = slot_valid & ~freeze & ~redirect;
   // Acks are only meaningful against an outstanding request; stray pulses
   // (e.g. in IDLE right after reset, or in HOLD) are ignored.
   assign ack_live  = imem_ack & imem_req;
   assign fetch_ok  = ack_live & (state == S_REQ) & ~redirect;
   assign fetch_pc4 = fetch_addr + 32'd4;
   // Slot still occupied after this edge -> the new word lands in the skid.
   assign to_skid   = fetch_ok & slot_valid & ~consume;

   // Holding queue: output slot plus skid.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         slot_inst  <= '0;
         slot_pc4   <= '0;
         slot_valid <= 1'b0;
         skid_inst  <= '0;
         skid_pc4   <= '0;
         skid_valid <= 1'b0;
      end else if (redirect) begin
         slot_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         // A valid skid implies HOLD, so no ack can compete with the refill.
         if (consume && skid_valid) begin
            slot_inst  <= skid_inst;
            slot_pc4   <= skid_pc4;
            skid_valid <= 1'b0;
         end else if (fetch_ok && (!slot_valid || consume)) begin
            slot_inst  <= imem_rdata;
            slot_pc4   <= fetch_pc4;
            slot_valid <= 1'b1;
         end else if (consume) begin
            slot_valid <= 1'b0;
         end
         if (to_skid) begin
            skid_inst  <= imem_rdata;
            skid_pc4   <= fetch_pc4;
            skid_valid <= 1'b1;
         end
      end
   end

   // Fetch FSM. imem_req is registered and tracks REQ/DRAIN.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state      <= S_IDLE;
         imem_req   <= 1'b0;
         pc         <= RESET_PC;
         fetch_addr <= RESET_PC;
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_REQ;
               imem_req <= 1'b1;
               if (redirect) begin
                  pc         <= redirect_pc;
                  fetch_addr <= redirect_pc;
               end
            end
            S_REQ: begin
               if (redirect) begin
                  pc <= redirect_pc;
                  if (ack_live) begin
                     fetch_addr <= redirect_pc;
                  end else begin
                     // Request already on the bus: must see its ack first.
                     state <= S_DRAIN;
                  end
               end else if (ack_live) begin
                  pc         <= fetch_pc4;
                  fetch_addr <= fetch_pc4;
                  if (to_skid) begin
                     state    <= S_HOLD;
                     imem_req <= 1'b0;
                  end
               end
            end
            S_HOLD: begin
               if (redirect) begin
                  pc         <= redirect_pc;
                  fetch_addr <= redirect_pc;
                  state      <= S_REQ;
                  imem_req   <= 1'b1;
               end else if (consume) begin
                  state    <= S_REQ;
                  imem_req <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (redirect) pc <= redirect_pc;
               if (ack_live) begin
                  fetch_addr <= redirect ? redirect_pc : pc;
                  state      <= S_REQ;
               end
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic       squash_ack;
   logic [1:0] squash_n;

   assign squash_ack = ack_live & (((state == S_REQ) & redirect) | (state == S_DRAIN));
   assign squash_n   = {1'b0, squash_ack} + {1'b0, redirect & slot_valid}
                     + {1'b0, redirect & skid_valid};

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         perf_fetched  <= '0;
         perf_squashed <= '0;
      end else begin
         if (consume) perf_fetched <= perf_fetched + 32'd1;
         perf_squashed <= perf_squashed + {30'd0, squash_n};
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit -- directed bench for if_fetch_unit.
// Memory model returns the fetch address as data with a programmable
// latency. Expected instructions are queued by the stimulus; a negedge
// monitor pops and compares on every consume. A second instance checks
// RESET_PC wrap-around. Perf counters are checked when FETCH_PERF_EN is set.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_b, freeze, redirect, force_ack;
   logic [31:0] redirect_pc;
   int          lat, wcnt;

   logic        imem_req, imem_ack, inst_valid, flush_out;
   logic [31:0] imem_addr, imem_rdata, pc_out, inst_out;

   logic        req2, valid2, flush2;
   logic [31:0] addr2, pc_out2, inst_out2;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched, perf_squashed, perf_fetched2, perf_squashed2;
`endif

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb[$];

   always #5 clk = ~clk;

   // Latency-programmable memory; force_ack injects stray acks.
   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) wcnt <= 0;
      else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
      else wcnt <= 0;
   end
   assign imem_ack   = force_ack | (imem_req & (wcnt == lat - 1));
   assign imem_rdata = imem_addr;

   if_fetch_unit u_dut (
      .clk(clk), .rst_b(rst_b), .freeze(freeze), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
      .inst_out(inst_out), .inst_valid(inst_valid),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched), .perf_squashed(perf_squashed),
`endif
      .flush_out(flush_out)
   );

   // Zero-wait memory, never frozen or redirected.
   if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
      .clk(clk), .rst_b(rst_b), .freeze(1'b0), .redirect(1'b0),
      .redirect_pc(32'h0), .imem_req(req2), .imem_addr(addr2),
      .imem_ack(req2), .imem_rdata(addr2), .pc_out(pc_out2),
      .inst_out(inst_out2), .inst_valid(valid2),
`ifdef FETCH_PERF_EN
      .perf_fetched(perf_fetched2), .perf_squashed(perf_squashed2),
`endif
      .flush_out(flush2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a);
      sb.push_back(a);
   endtask

   // Scoreboard monitor: every consume must match the next queued word.
   always @(negedge clk) begin
      if (rst_b && inst_valid && !freeze && !redirect) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected: got inst %h with empty queue", inst_out);
         end else begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("sb_inst", inst_out, e);
            chk("sb_pc",   pc_out,   e + 32'd4);
         end
      end
   end

   initial begin
      rst_b = 1'b0; freeze = 1'b0; redirect = 1'b0; redirect_pc = '0;
      force_ack = 1'b0; lat = 1;

      // Reset values
      repeat (2) step();
      chk("rst_req",   {31'd0, imem_req},   32'd0);
      chk("rst_addr",  imem_addr,           32'h0);
      chk("rst_inst",  inst_out,            32'h0);
      chk("rst_pc",    pc_out,              32'h0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_flush", {31'd0, flush_out},  32'd1);

      // Zero-wait streaming, then freeze to fill the skid
      rst_b = 1'b1;
      push(32'h0); push(32'h4); push(32'h8); push(32'hC);
      step();
      chk("e1_req",   {31'd0, imem_req},   32'd1);
      chk("e1_addr",  imem_addr,           32'h0);
      chk("e1_valid", {31'd0, inst_valid}, 32'd0);
      chk("e1_flush", {31'd0, flush_out},  32'd1);
      chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
      step();
      chk("e2_addr",  imem_addr,          32'h4);
      chk("e2_inst",  inst_out,           32'h0);
      chk("e2_pc",    pc_out,             32'h4);
      chk("e2_flush", {31'd0, flush_out}, 32'd0);
      chk("wrap_addr1", addr2,     32'h0);
      chk("wrap_inst",  inst_out2, 32'hFFFF_FFFC);
      chk("wrap_pc",    pc_out2,   32'h0);
      step();
      chk("e3_addr", imem_addr, 32'h8);
      chk("e3_inst", inst_out,  32'h4);
      step();
      chk("e4_inst", inst_out, 32'h8);
      freeze = 1'b1;
      step();
      chk("frz_req",   {31'd0, imem_req},   32'd0);
      chk("frz_valid", {31'd0, inst_valid}, 32'd1);
      repeat (4) begin
         step();
         chk("frz_hold_req",  {31'd0, imem_req}, 32'd0);
         chk("frz_hold_inst", inst_out,          32'h8);
      end
      freeze = 1'b0;
      step();
      chk("unfrz_inst", inst_out,         32'hC);
      chk("unfrz_pc",   pc_out,           32'h10);
      chk("unfrz_req",  {31'd0, imem_req}, 32'd1);
      chk("unfrz_addr", imem_addr,        32'h10);
      step();

      // Reset asserted mid-request
      freeze = 1'b1; rst_b = 1'b0;
      #1;
      chk("mid_rst_req",   {31'd0, imem_req},   32'd0);
      chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("mid_rst_flush", {31'd0, flush_out},  32'd1);
      chk("mid_rst_addr",  imem_addr,           32'h0);
      chk("sb_drained_1",  32'(sb.size()),      32'd0);

      // 3-cycle memory, redirect during the second wait cycle -> DRAIN
      lat = 3; freeze = 1'b0; force_ack = 1'b1;
      step();
      rst_b = 1'b1;
      push(32'h100);
      step();
      force_ack = 1'b0;
      chk("idle_ack_ignored", {31'd0, inst_valid}, 32'd0);
      chk("d_e1_req", {31'd0, imem_req}, 32'd1);
      step();
      redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      chk("d_redir_flush", {31'd0, flush_out}, 32'd1);
      step();
      redirect = 1'b0;
      chk("drain_req",   {31'd0, imem_req},   32'd1);
      chk("drain_addr",  imem_addr,           32'h0);
      step();
      chk("drain_valid", {31'd0, inst_valid}, 32'd0);
      chk("post_drain_addr", imem_addr,       32'h100);
      step(); step();
      chk("drain_still_empty", {31'd0, inst_valid}, 32'd0);
      step();
      chk("tgt_inst",  inst_out,            32'h100);
      chk("tgt_valid", {31'd0, inst_valid}, 32'd1);
      step();
      rst_b = 1'b0;
      #1;
      chk("sb_drained_2", 32'(sb.size()), 32'd0);

      // Redirect + freeze + stray ack with slot and skid valid
      lat = 1; freeze = 1'b1;
      step();
      rst_b = 1'b1;
      for (int i = 0; i < 10; i++) push(32'h200 + 32'(4 * i));
      push(32'h300);
      step(); step();
      chk("fill_inst", inst_out, 32'h0);
      step();
      chk("fill_req",   {31'd0, imem_req},   32'd0);
      chk("fill_valid", {31'd0, inst_valid}, 32'd1);
      redirect = 1'b1; redirect_pc = 32'h200; force_ack = 1'b1;
      #1;
      chk("rfa_flush", {31'd0, flush_out}, 32'd1);
      step();
      redirect = 1'b0; force_ack = 1'b0; freeze = 1'b0;
      chk("rfa_valid", {31'd0, inst_valid}, 32'd0);
      chk("rfa_flush_after", {31'd0, flush_out}, 32'd1);
      chk("rfa_req",   {31'd0, imem_req},   32'd1);
      chk("rfa_addr",  imem_addr,           32'h200);
`ifdef FETCH_PERF_EN
      chk("perf_sq_hold", perf_squashed, 32'd2);
      chk("perf_f0",      perf_fetched,  32'd0);
`endif
      repeat (11) step();
      chk("run_inst", inst_out, 32'h228);
`ifdef FETCH_PERF_EN
      chk("perf_f10",  perf_fetched,  32'd10);
      chk("perf_sq2",  perf_squashed, 32'd2);
`endif
      // Redirect with slot valid and an ack in the same cycle
      freeze = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
      step();
      redirect = 1'b0; freeze = 1'b0;
      chk("ra_valid", {31'd0, inst_valid}, 32'd0);
      chk("ra_addr",  imem_addr,           32'h300);
`ifdef FETCH_PERF_EN
      chk("perf_sq4", perf_squashed, 32'd4);
      chk("perf_f10b", perf_fetched, 32'd10);
`endif
      step();
      chk("ra_inst", inst_out, 32'h300);
      step();
      freeze = 1'b1;
`ifdef FETCH_PERF_EN
      chk("perf_f11", perf_fetched, 32'd11);
`endif
      step();
      chk("sb_drained_3", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
